// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared constants and state encoding for the shift-add
//                multiplier sequencing controller (mult_control).
//                  MULT_BITS - number of add/shift iterations (operand width)
//                  CNT_W     - width of the iteration counter
//                  state_t   - controller state encoding
//                  is_last_bit() - true when the counter addresses the sign bit
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_BITS = 8;
    localparam int CNT_W     = $clog2(MULT_BITS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_B    = 3'd1,
        LD_CLR  = 3'd2,
        LD_HOLD = 3'd3,
        CLEAR   = 3'd4,
        ADD     = 3'd5,
        SHIFT   = 3'd6,
        DONE    = 3'd7
    } state_t;

    // The final iteration handles the multiplier sign bit, which carries
    // negative weight in two's complement and therefore needs a subtract.
    function automatic logic is_last_bit(input logic [CNT_W-1:0] count);
        return (count == CNT_W'(MULT_BITS - 1));
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_control.sv
`default_nettype none
// ============================================================================
//  Module      : mult_control
//  Description : Sequencing controller for the 8-bit signed shift-add
//                multiplier datapath (XAB shift register, X sign flop and
//                add/subtract adder). Converts the Run and ClearA_LoadB
//                levels into one-hot per-cycle datapath strobes.
//
//  Ports       : Clk          in  system clock, rising edge
//                Reset        in  synchronous active-high reset
//                Run          in  start a multiply (sampled in IDLE only)
//                ClearA_LoadB in  load B from switches, then clear X:A
//                M            in  current multiplier LSB (XAB[0])
//                Load_B       out load B from switches
//                Clear_XA     out clear A and the X flip-flop
//                Compute      out load A with the adder result
//                Load_X       out load X with the adder sign bit
//                Fn           out adder function, 0 = add, 1 = subtract
//                Shift_En     out arithmetic right shift of X:A:B
//                Busy         out high in CLEAR, ADD and SHIFT
//                Done         out high in DONE
//
//  Build option: MULT_SKIP_ADD_EN - when defined, an iteration whose
//                multiplier bit is 0 shifts in the ADD cycle itself, so a
//                multiply takes 1 + MULT_BITS + popcount(B) busy cycles.
//                When undefined every bit takes exactly two cycles.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_control
    import mult_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Load_B,
    output logic Clear_XA,
    output logic Compute,
    output logic Load_X,
    output logic Fn,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_last_bit;

    assign w_last_bit = is_last_bit(r_count);

    // ------------------------------------------------------------------
    // State and iteration counter
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath strobes. The datapath resolves overlapping
    // strobes by priority, so every state raises at most one of Load_B,
    // Compute, Clear_XA and Shift_En; that keeps the sequence explicit
    // rather than relying on the datapath's priority order.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        Load_B       = 1'b0;
        Clear_XA     = 1'b0;
        Compute      = 1'b0;
        Load_X       = 1'b0;
        Fn           = 1'b0;
        Shift_En     = 1'b0;
        Busy         = 1'b0;
        Done         = 1'b0;

        case (r_state)
            IDLE: begin
                // Run takes precedence when both requests arrive together.
                if (Run) begin
                    w_state_next = CLEAR;
                end else if (ClearA_LoadB) begin
                    w_state_next = LD_B;
                end
            end

            LD_B: begin
                Load_B       = 1'b1;
                w_state_next = LD_CLR;
            end

            LD_CLR: begin
                Clear_XA     = 1'b1;
                w_state_next = LD_HOLD;
            end

            LD_HOLD: begin
                // A switch held down must not reload on every pass
                // through IDLE, so wait for the level to drop.
                if (!ClearA_LoadB) begin
                    w_state_next = IDLE;
                end
            end

            CLEAR: begin
                Clear_XA     = 1'b1;
                Busy         = 1'b1;
                w_count_next = '0;
                w_state_next = ADD;
            end

            ADD: begin
                Busy = 1'b1;
                // Fn, Compute and Load_X follow M within the cycle. M is
                // stable here because B moves only on Shift_En or Load_B.
                Fn   = w_last_bit;
                if (M) begin
                    Compute      = 1'b1;
                    Load_X       = 1'b1;
                    w_state_next = SHIFT;
                end else begin
`ifdef MULT_SKIP_ADD_EN
                    // Nothing to add: shift now and move straight on to
                    // the next bit (or finish after the sign bit).
                    Shift_En     = 1'b1;
                    w_count_next = r_count + CNT_W'(1);
                    w_state_next = w_last_bit ? DONE : ADD;
`else
                    // Keep two cycles per bit so latency is data independent.
                    w_state_next = SHIFT;
`endif
                end
            end

            SHIFT: begin
                Busy         = 1'b1;
                Shift_En     = 1'b1;
                w_count_next = r_count + CNT_W'(1);
                w_state_next = w_last_bit ? DONE : ADD;
            end

            DONE: begin
                Done = 1'b1;
                // Holding Run keeps the result on display; a new multiply
                // needs Run to drop for at least one cycle first.
                if (!Run) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule : mult_control
`default_nettype wire

// File: doc/mult_control.md
# mult_control

Sequencing controller for the 8-bit signed shift-add multiplier datapath: the XAB shift register, the X sign flip-flop and the add/subtract adder. It turns the operator-level Run and ClearA_LoadB levels into one-hot per-cycle datapath strobes. It runs eight add/shift iterations, using subtract on the final (sign) bit, then holds until Run is released. The block sits between the debounced and synchronised switch inputs and the datapath, inside the lab 5 top level.

## Interface
- MULT_BITS, 8, number of add/shift iterations (multiplier width); counter width is clog2(MULT_BITS)
- Clk  in  1  system clock, all state changes on rising edge
- Reset  in  1  synchronous, active-high; the only reset
- Run  in  1  level, already synchronised; starts a multiply from IDLE
- ClearA_LoadB  in  1  level, already synchronised; loads B from S, then clears X:A
- M  in  1  current multiplier LSB (XAB[0])
- Load_B  out  1  load B from switches
- Clear_XA  out  1  clear A; the top level also routes it to X flip-flop Reset
- Compute  out  1  load A with adder result
- Load_X  out  1  load X with adder sign bit S[8]
- Fn  out  1  adder function: 0 = add, 1 = subtract
- Shift_En  out  1  arithmetic right shift of X:A:B
- Busy  out  1  high in CLEAR, ADD, SHIFT
- Done  out  1  high in DONE

## Operation
- The datapath gives Load_B > Compute > Clear_XA > Shift_En priority. The controller therefore never asserts more than one of these four in a cycle. Load_X asserts only together with Compute.
- States:
  - IDLE: if Run=1, go to CLEAR. Else if ClearA_LoadB=1, go to LD_B. Run wins when both are high.
  - LD_B: Load_B=1, then go to LD_CLR.
  - LD_CLR: Clear_XA=1, then go to LD_HOLD.
  - LD_HOLD: wait for ClearA_LoadB=0, then go to IDLE. A held level causes no retrigger.
  - CLEAR: Clear_XA=1, count←0, then go to ADD.
  - ADD: Fn = (count==MULT_BITS-1).
    - If M=1: Compute=1, Load_X=1, then go to SHIFT.
    - If M=0: no strobe, then go to SHIFT. The skip-add variant differs; see Configuration.
  - SHIFT: Shift_En=1, count←count+1. If count==MULT_BITS-1, go to DONE; else go to ADD.
  - DONE: hold until Run=0, then go to IDLE.
- Compute, Load_X and Fn are Mealy on M in ADD. M is stable in ADD because B changes only on Shift_En or Load_B.
- Run falling mid-multiply is ignored. The multiply completes, and DONE then lasts exactly 1 cycle.
- Run or ClearA_LoadB asserted outside IDLE is ignored.
- Result: X:A:B holds the 16-bit two's-complement product (A high, B low).

## Timing
- Reset (any state, including mid-multiply): next state IDLE, count=0, all outputs 0. Datapath contents are not guaranteed consistent afterwards.
- Run sampled high in IDLE: CLEAR is the next cycle, followed by 16 cycles of ADD/SHIFT. Done rises 17 cycles after the CLEAR cycle begins.
- Busy is high for exactly 17 cycles per multiply (fixed-latency build).
- ClearA_LoadB sampled high in IDLE: Load_B one cycle, then Clear_XA one cycle, then LD_HOLD.
- Back-to-back: Run held high keeps DONE. A new multiply needs Run low for at least 1 cycle (IDLE), then high.

## Configuration
- MULT_SKIP_ADD_EN defined:
  - In ADD with M=0, assert Shift_En that same cycle and increment count.
  - Stay in ADD, or go to DONE after the last bit.
  - SHIFT is taken only after a Compute.
  - Busy length = 1 + MULT_BITS + popcount(B).
- Not defined: fixed 2 cycles per bit, as described above.

## Structure
- Package mult_pkg holds:
  - MULT_BITS constant.
  - state_t enum: IDLE, LD_B, LD_CLR, LD_HOLD, CLEAR, ADD, SHIFT, DONE.
  - CNT_W = $clog2(MULT_BITS).
- Single module: state register plus counter, with combinational next-state and output logic. No sub-module; the counter is too small to split out.

## Test plan
Bench instantiates mult_control with the real datapath.
- ClearA_LoadB pulse with S=0x07:
  - Load_B, then Clear_XA, on consecutive cycles.
  - B=0x07, A=0x00, X=0.
  - Holding the level for 5 cycles adds no further strobes.
- B=0x07, S=0x3B, Run:
  - X:A:B → A:B=0x019D.
  - Done asserted exactly 17 cycles after CLEAR (fixed build).
- B=0x3B, S=0xF9 (−7): A:B=0xFE63 (−413).
- B=0xFF (−1), S=0x02:
  - Fn=1 only in the bit-7 ADD cycle.
  - A:B=0xFFFE.
- Reset asserted at bit 3 SHIFT:
  - Next cycle is IDLE, all outputs 0.
  - A subsequent load plus Run gives the correct product.
- MULT_SKIP_ADD_EN:
  - B=0x00: Busy is 9 cycles.
  - B=0xFF: Busy is 17 cycles.
  - Products match the fixed build.
  - Run held high through DONE gives no restart.
